// File: rtl/player_shot.sv
// player_shot: player projectile stage.
// Launches one shot on a rising edge of the ship's fire level, walks it up
// the screen in fixed steps, holds a short red flash after a hit, and draws
// its own pixel layer (black elsewhere) for OR-merging into the VGA mixer.
module player_shot #(
  parameter int START_Y    = 488,
  parameter int TOP_Y      = 40,
  parameter int STEP_PX    = 4,
  parameter int STEP_DIV   = 250000,
  parameter int X_OFFSET   = 10,
  parameter int SHOT_W     = 2,
  parameter int SHOT_H     = 8,
  parameter int EXPL_STEPS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire,
  input  logic [10:0] pos_nave,
  input  logic        hit_ack,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  output logic [10:0] posX_shot,
  output logic [10:0] posY_shot,
  output logic        shot_active,
  output logic        shot_done,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int EXP_W = $clog2(EXPL_STEPS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_DIV - 1);
  localparam logic [EXP_W-1:0] EXPL_LAST = EXP_W'(EXPL_STEPS - 1);
  localparam logic [10:0]      START_Y_C = 11'(START_Y);
  localparam logic [10:0]      RETIRE_Y  = 11'(TOP_Y + STEP_PX);
  localparam logic [10:0]      STEP_C    = 11'(STEP_PX);
  localparam logic [10:0]      X_OFF_C   = 11'(X_OFFSET);

  // 12-bit geometry constants so right/bottom bounds never wrap.
  localparam logic [11:0] SHOT_W_C = 12'(SHOT_W);
  localparam logic [11:0] SHOT_H_C = 12'(SHOT_H);
  localparam logic [11:0] EXPL_L_C = 12'd2;
  localparam logic [11:0] EXPL_R_C = 12'd4;
  localparam logic [11:0] EXPL_H_C = 12'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_FLY,
    S_EXPL
  } state_t;

  state_t           state_q, state_d;
  logic             fire_q;
  logic [10:0]      x_q, x_d;
  logic [10:0]      y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] expl_q, expl_d;
  logic             done_q, done_d;
  logic [7:0]       r_q, g_q, b_q;
  logic [7:0]       r_d, g_d, b_d;

  logic launch_ev;
  logic tick;

  assign launch_ev = fire & ~fire_q;
  assign tick      = (cnt_q == CNT_LAST);

  // State, position, counters and edge detector registers.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them sample the
    // pre-edge values; a blocking = would let later lines see new values.
    if (reset) begin
      state_q <= S_IDLE;
      fire_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      expl_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fire_q  <= fire;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      expl_q  <= expl_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: launch, stepping, hit priority and retire.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    expl_d  = expl_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        x_d    = '0;
        y_d    = '0;
        cnt_d  = '0;
        expl_d = '0;
        if (launch_ev) state_d = S_LAUNCH;
      end

      S_LAUNCH: begin
        // 11-bit wrap is intentional; the ship never sits that far right.
        x_d     = pos_nave + X_OFF_C;
        y_d     = START_Y_C;
        cnt_d   = '0;
        state_d = S_FLY;
      end

      S_FLY: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (hit_ack) begin
          // Hit wins over a coincident step or retire; position freezes.
          state_d = S_EXPL;
          cnt_d   = '0;
          expl_d  = '0;
        end else if (tick) begin
          if (y_q < RETIRE_Y) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
          end else begin
            y_d = y_q - STEP_C;
          end
        end
      end

      S_EXPL: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          if (expl_q == EXPL_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
            expl_d  = '0;
          end else begin
            expl_d = expl_q + EXP_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Pixel hit test against the current shot / flash rectangle.
  logic [11:0] h_ext, v_ext, x_ext, y_ext, expl_left;
  logic        in_fly, in_expl;

  always_comb begin
    h_ext     = {2'b00, h_counter};
    v_ext     = {2'b00, v_counter};
    x_ext     = {1'b0, x_q};
    y_ext     = {1'b0, y_q};
    // Flash extends 2 px left of the shot, clamped at the screen edge.
    expl_left = (x_ext < EXPL_L_C) ? 12'd0 : x_ext - EXPL_L_C;

    in_fly  = (state_q == S_FLY)
              && (h_ext >= x_ext) && (h_ext < x_ext + SHOT_W_C)
              && (v_ext >= y_ext) && (v_ext < y_ext + SHOT_H_C);
    in_expl = (state_q == S_EXPL)
              && (h_ext >= expl_left) && (h_ext < x_ext + EXPL_R_C)
              && (v_ext >= y_ext) && (v_ext < y_ext + EXPL_H_C);

    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    if (in_fly) begin
      r_d = 8'hFF;
      g_d = 8'hFF;
    end else if (in_expl) begin
      r_d = 8'hFF;
    end
  end

  // Registered colour output, one clock behind the VGA counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 8'h00;
      g_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign posX_shot   = x_q;
  assign posY_shot   = y_q;
  assign shot_active = (state_q == S_FLY);
  assign shot_done   = done_q;
  assign R           = r_q;
  assign G           = g_q;
  assign B           = b_q;

endmodule

// File: tb/tb_player_shot.sv
// Testbench for player_shot with a fast step divider (STEP_DIV = 4).
module tb_player_shot;

  localparam int STEP_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fire;
  logic [10:0] pos_nave;
  logic        hit_ack;
  logic [9:0]  h_counter;
  logic [9:0]  v_counter;
  logic [10:0] posX_shot;
  logic [10:0] posY_shot;
  logic        shot_active;
  logic        shot_done;
  logic [7:0]  R, G, B;

  int checks = 0;
  int errors = 0;

  logic [23:0] pix_q[$];
  logic [10:0] y_exp_q[$];

  player_shot #(.STEP_DIV(STEP_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .fire       (fire),
    .pos_nave   (pos_nave),
    .hit_ack    (hit_ack),
    .h_counter  (h_counter),
    .v_counter  (v_counter),
    .posX_shot  (posX_shot),
    .posY_shot  (posY_shot),
    .shot_active(shot_active),
    .shot_done  (shot_done),
    .R          (R),
    .G          (G),
    .B          (B)
  );

  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    fire    = 1'b0;
    hit_ack = 1'b0;
    tick_clk();
    tick_clk();
    reset = 1'b0;
    tick_clk();
  endtask

  // Drives a clean fire edge; returns on the cycle shot_active should rise.
  task automatic launch(input logic [10:0] nave);
    fire     = 1'b0;
    pos_nave = nave;
    tick_clk();
    fire = 1'b1;
    tick_clk();
    tick_clk();
  endtask

  task automatic wait_y(input logic [10:0] target, input int budget, input string name);
    int n = 0;
    while (posY_shot !== target && n < budget) begin
      tick_clk();
      n++;
    end
    checks++;
    if (posY_shot !== target) begin
      errors++;
      $display("FAIL %s: timed out waiting for posY_shot, got %0d need %0d", name, posY_shot, target);
    end
  endtask

  task automatic drive_pix(input logic [9:0] h, input logic [9:0] v, input logic [23:0] exp_rgb);
    h_counter = h;
    v_counter = v;
    pix_q.push_back(exp_rgb);
  endtask

  task automatic check_pix(input string name);
    logic [23:0] exp_rgb;
    exp_rgb = pix_q.pop_front();
    checks++;
    if ({R, G, B} !== exp_rgb) begin
      errors++;
      $display("FAIL %s: rgb got %06h need %06h", name, {R, G, B}, exp_rgb);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    fire      = 1'b0;
    hit_ack   = 1'b0;
    pos_nave  = 11'd0;
    h_counter = 10'd0;
    v_counter = 10'd0;
    tick_clk();
    tick_clk();
    checks++;
    if ({posX_shot, posY_shot, shot_active, shot_done, R, G, B} !== '0) begin
      errors++;
      $display("FAIL reset_state: got x=%0d y=%0d act=%b done=%b rgb=%06h need all zero",
               posX_shot, posY_shot, shot_active, shot_done, {R, G, B});
    end
    reset = 1'b0;
    tick_clk();
  endtask

  task automatic test_launch();
    fire     = 1'b0;
    pos_nave = 11'd445;
    tick_clk();
    fire = 1'b1;
    tick_clk();
    checks++;
    if (shot_active !== 1'b0) begin
      errors++;
      $display("FAIL launch_latency1: shot_active got %b need 0", shot_active);
    end
    tick_clk();
    checks++;
    if (posX_shot !== 11'd455 || posY_shot !== 11'd488 || shot_active !== 1'b1) begin
      errors++;
      $display("FAIL launch: got x=%0d y=%0d act=%b need x=455 y=488 act=1",
               posX_shot, posY_shot, shot_active);
    end
    repeat (4) tick_clk();
    checks++;
    if (posY_shot !== 11'd484) begin
      errors++;
      $display("FAIL first_step: posY_shot got %0d need 484", posY_shot);
    end
  endtask

  // Continues the flight from test_launch with fire still held high.
  task automatic test_full_flight();
    logic [10:0] prev;
    logic [10:0] exp_y;
    bit          seen_done;
    int          active_cycles;
    prev      = 11'd484;
    seen_done = 1'b0;
    for (int y = 480; y >= 40; y -= 4) y_exp_q.push_back(11'(y));
    for (int n = 0; n < 600 && !seen_done; n++) begin
      tick_clk();
      if (shot_done === 1'b1) begin
        seen_done = 1'b1;
      end else if (posY_shot !== prev) begin
        exp_y = (y_exp_q.size() > 0) ? y_exp_q.pop_front() : 11'h7FF;
        checks++;
        if (posY_shot !== exp_y) begin
          errors++;
          $display("FAIL flight_step: posY_shot got %0d need %0d", posY_shot, exp_y);
        end
        prev = posY_shot;
      end
    end
    checks++;
    if (!seen_done || y_exp_q.size() != 0) begin
      errors++;
      $display("FAIL retire: done_seen=%0d steps_left=%0d need done_seen=1 steps_left=0",
               seen_done, y_exp_q.size());
    end
    y_exp_q.delete();
    checks++;
    if (posX_shot !== 11'd0 || posY_shot !== 11'd0 || shot_active !== 1'b0) begin
      errors++;
      $display("FAIL retire_state: got x=%0d y=%0d act=%b need 0 0 0", posX_shot, posY_shot, shot_active);
    end
    tick_clk();
    checks++;
    if (shot_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: shot_done got %b need 0", shot_done);
    end
    active_cycles = 0;
    repeat (10) begin
      tick_clk();
      if (shot_active === 1'b1) active_cycles++;
    end
    checks++;
    if (active_cycles != 0) begin
      errors++;
      $display("FAIL held_fire_relaunch: active cycles got %0d need 0", active_cycles);
    end
    launch(11'd100);
    checks++;
    if (posX_shot !== 11'd110 || posY_shot !== 11'd488 || shot_active !== 1'b1) begin
      errors++;
      $display("FAIL second_launch: got x=%0d y=%0d act=%b need x=110 y=488 act=1",
               posX_shot, posY_shot, shot_active);
    end
  endtask

  task automatic test_hit();
    int done_n;
    do_reset();
    launch(11'd445);
    wait_y(11'd300, 600, "hit_wait");
    hit_ack = 1'b1;
    tick_clk();
    hit_ack = 1'b0;
    checks++;
    if (shot_active !== 1'b0 || posY_shot !== 11'd300 || posX_shot !== 11'd455 || shot_done !== 1'b0) begin
      errors++;
      $display("FAIL hit_enter: got x=%0d y=%0d act=%b done=%b need x=455 y=300 act=0 done=0",
               posX_shot, posY_shot, shot_active, shot_done);
    end
    done_n = -1;
    for (int n = 1; n <= 40 && done_n < 0; n++) begin
      if (n == 1) drive_pix(10'd453, 10'd300, 24'hFF0000);
      if (n == 2) drive_pix(10'd459, 10'd300, 24'h000000);
      if (n == 3) hit_ack = 1'b1;
      if (n == 4) hit_ack = 1'b0;
      tick_clk();
      if (n == 1) check_pix("expl_pix_left");
      if (n == 2) check_pix("expl_pix_right");
      if (n == 4) begin
        checks++;
        if (shot_active !== 1'b0 || posY_shot !== 11'd300) begin
          errors++;
          $display("FAIL second_hit: got act=%b y=%0d need act=0 y=300", shot_active, posY_shot);
        end
      end
      if (shot_done === 1'b1) done_n = n;
    end
    checks++;
    if (done_n != 32) begin
      errors++;
      $display("FAIL expl_duration: shot_done at clk %0d need 32", done_n);
    end
    tick_clk();
    checks++;
    if (shot_done !== 1'b0 || posX_shot !== 11'd0 || posY_shot !== 11'd0) begin
      errors++;
      $display("FAIL expl_idle: got done=%b x=%0d y=%0d need 0 0 0", shot_done, posX_shot, posY_shot);
    end
  endtask

  task automatic test_pixel();
    do_reset();
    launch(11'd445);
    wait_y(11'd300, 600, "pix_wait");
    drive_pix(10'd455, 10'd300, 24'hFFFF00);
    tick_clk();
    check_pix("fly_pix_origin");
    drive_pix(10'd457, 10'd300, 24'h000000);
    tick_clk();
    check_pix("fly_pix_right_edge");
    drive_pix(10'd456, 10'd307, 24'hFFFF00);
    tick_clk();
    check_pix("fly_pix_bottom_row");
    drive_pix(10'd456, 10'd308, 24'h000000);
    tick_clk();
    check_pix("fly_pix_below");
    h_counter = 10'd0;
    v_counter = 10'd0;
  endtask

  task automatic test_simultaneous();
    bit seen_done;
    do_reset();
    launch(11'd445);
    fire = 1'b0;
    tick_clk();
    fire = 1'b1;
    repeat (3) tick_clk();
    checks++;
    if (posY_shot !== 11'd484 || shot_active !== 1'b1 || posX_shot !== 11'd455) begin
      errors++;
      $display("FAIL fire_in_fly: got x=%0d y=%0d act=%b need x=455 y=484 act=1",
               posX_shot, posY_shot, shot_active);
    end
    wait_y(11'd40, 600, "top_wait");
    repeat (3) tick_clk();
    hit_ack = 1'b1;
    tick_clk();
    hit_ack = 1'b0;
    checks++;
    if (shot_done !== 1'b0 || shot_active !== 1'b0 || posY_shot !== 11'd40) begin
      errors++;
      $display("FAIL hit_vs_retire: got done=%b act=%b y=%0d need done=0 act=0 y=40",
               shot_done, shot_active, posY_shot);
    end
    seen_done = 1'b0;
    for (int n = 0; n < 40 && !seen_done; n++) begin
      tick_clk();
      if (shot_done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL hit_vs_retire_done: shot_done got 0 need 1 within 40 clk");
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    launch(11'd445);
    wait_y(11'd200, 600, "reset_wait");
    reset = 1'b1;
    fire  = 1'b0;
    tick_clk();
    checks++;
    if ({posX_shot, posY_shot, shot_active, shot_done, R, G, B} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got x=%0d y=%0d act=%b done=%b need all zero",
               posX_shot, posY_shot, shot_active, shot_done);
    end
    reset = 1'b0;
    tick_clk();
    checks++;
    if (shot_done !== 1'b0 || shot_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got done=%b act=%b need 0 0", shot_done, shot_active);
    end
    tick_clk();
    fire = 1'b1;
    tick_clk();
    tick_clk();
    checks++;
    if (posY_shot !== 11'd488 || posX_shot !== 11'd455 || shot_active !== 1'b1) begin
      errors++;
      $display("FAIL relaunch_after_reset: got x=%0d y=%0d act=%b need x=455 y=488 act=1",
               posX_shot, posY_shot, shot_active);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_full_flight();
    test_hit();
    test_pixel();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
